// File: rtl/sseg_display_sched.sv
// sseg_display_sched: owns the 8-digit multiplexed seven-segment display.
// Source A is a live 32-bit hex value shown in the background. Source B is a
// one-shot message, requested over a 4-phase req/ack handshake. It preempts A
// for HOLD_CYCLES clocks, and then A returns.
// digits[7i+6:7i] is digit i as active-low {a,b,c,d,e,f,g}. It is registered
// with a latency of one cycle from the selected source.
// Optional build macro SSEG_SCHED_BLINK_EN: the message blinks while it is
// shown, gated by hold-counter bit BLINK_BIT.
module sseg_display_sched #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned BLINK_BIT   = 24
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [31:0] a_val,
  input  logic        a_lzb,
  input  logic        b_req,
  input  logic [31:0] b_val,
  input  logic [7:0]  b_mask,
  output logic        b_ack,
  output logic        b_busy,
  output logic        src_b,
  output logic [55:0] digits
);

  localparam logic [1:0] ST_SHOW_A = 2'd0;
  localparam logic [1:0] ST_SHOW_B = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segment code {a,b,c,d,e,f,g}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      msg_val_q, msg_val_d;
  logic [7:0]       msg_mask_q, msg_mask_d;
  logic [55:0]      digits_q, digits_d;
  logic             lead_zero;

  // Scheduler: accept a request only from SHOW_A, which is reached again only
  // after b_req has been seen low. A stuck-high request therefore cannot
  // retrigger.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    msg_val_d  = msg_val_q;
    msg_mask_d = msg_mask_q;
    case (state_q)
      ST_SHOW_A: begin
        if (b_req) begin
          state_d    = ST_SHOW_B;
          cnt_d      = '0;
          msg_val_d  = b_val;
          msg_mask_d = b_mask;
        end
      end
      ST_SHOW_B: begin
        // b_req dropping early is ignored; the message always runs its hold
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (!b_req) begin
          state_d = ST_SHOW_A;
        end
      end
      default: begin
        state_d = ST_SHOW_A;
      end
    endcase
  end

  // Next display image follows the next state, so digits and src_b change
  // on the same edge and B is shown for exactly HOLD_CYCLES cycles
  always_comb begin
    digits_d  = '1;
    lead_zero = 1'b1;
    if (state_d == ST_SHOW_B) begin
      for (int i = 0; i < 8; i++) begin
        digits_d[7*i +: 7] = msg_mask_d[i] ? SEG_BLANK : hex_to_seg(msg_val_d[4*i +: 4]);
      end
`ifdef SSEG_SCHED_BLINK_EN
      if (cnt_d[BLINK_BIT]) begin
        digits_d = '1;
      end
`endif
    end else begin
      // Walk from the most significant digit down. Digit 0 always shows.
      for (int i = 7; i >= 0; i--) begin
        lead_zero = lead_zero & (a_val[4*i +: 4] == 4'h0);
        if (a_lzb && lead_zero && (i != 0)) begin
          digits_d[7*i +: 7] = SEG_BLANK;
        end else begin
          digits_d[7*i +: 7] = hex_to_seg(a_val[4*i +: 4]);
        end
      end
    end
  end

`ifndef SSEG_SCHED_BLINK_EN
  // Blink gating is not built; keep the bit referenced so BLINK_BIT has a sink
  logic unused_blink;
  assign unused_blink = cnt_d[BLINK_BIT];
`endif

  // Control and display registers: reset drops any in-flight message
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SHOW_A;
      cnt_q    <= '0;
      digits_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
    end
  end

  // Message latch: data only, meaningful once a request has been accepted
  always_ff @(posedge ck) begin
    msg_val_q  <= msg_val_d;
    msg_mask_q <= msg_mask_d;
  end

  assign src_b  = (state_q == ST_SHOW_B);
  assign b_ack  = (state_q == ST_ACK);
  assign b_busy = (state_q != ST_SHOW_A);
  assign digits = digits_q;

endmodule

// File: tb/tb_sseg_display_sched.sv
// Bench for sseg_display_sched: a message-level behavioural model is checked
// against the outputs on every falling edge. Directed literal checks pin the
// decode table, the leading-zero rule, the handshake and reset abort.
module tb_sseg_display_sched;

`ifdef SSEG_SCHED_BLINK_EN
  localparam int unsigned HOLD = 64;
`else
  localparam int unsigned HOLD = 10;
`endif
  localparam int unsigned BLINK = 3;
  localparam logic [55:0] ALL_BLANK = {56{1'b1}};

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_val = '0;
  logic        a_lzb = 1'b0;
  logic        b_req = 1'b0;
  logic [31:0] b_val = '0;
  logic [7:0]  b_mask = '0;
  logic        b_ack, b_busy, src_b;
  logic [55:0] digits;

  int n_checks = 0;
  int n_errors = 0;

  sseg_display_sched #(
    .HOLD_CYCLES(HOLD),
    .CNT_W      (8),
    .BLINK_BIT  (BLINK)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .a_val (a_val),
    .a_lzb (a_lzb),
    .b_req (b_req),
    .b_val (b_val),
    .b_mask(b_mask),
    .b_ack (b_ack),
    .b_busy(b_busy),
    .src_b (src_b),
    .digits(digits)
  );

  always #5 ck = ~ck;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  task automatic chk(input string name, input logic [55:0] got, input logic [55:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // A value as it must appear: digits above the highest nonzero nibble blank
  function automatic logic [55:0] render_a(input logic [31:0] v, input logic lzb);
    logic [55:0] r;
    int sig;
    sig = 1;
    for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) sig = i + 1;
    for (int i = 0; i < 8; i++)
      r[7*i +: 7] = (lzb && i >= sig) ? 7'h7F : seg_tab[(v >> (4 * i)) & 32'hF];
    return r;
  endfunction

  // Message as it must appear at a given age (cycles since it first showed)
  function automatic logic [55:0] render_b(input logic [31:0] v, input logic [7:0] m,
                                           input int unsigned age);
    logic [55:0] r;
    for (int i = 0; i < 8; i++)
      r[7*i +: 7] = m[i] ? 7'h7F : seg_tab[(v >> (4 * i)) & 32'hF];
`ifdef SSEG_SCHED_BLINK_EN
    if (((age >> BLINK) & 1) == 1) r = ALL_BLANK;
`else
    if (age > HOLD) r = ALL_BLANK;
`endif
    return r;
  endfunction

  // Behavioural model: a message is either showing (with its age), waiting for
  // the requester to drop b_req, or absent
  logic        m_in_msg = 1'b0;
  logic        m_wait_low = 1'b0;
  int unsigned m_age = 0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_mask = '0;
  logic [55:0] m_disp = ALL_BLANK;

  always @(posedge ck or negedge rst_n) begin : model
    logic        n_in, n_wait;
    int unsigned n_age;
    logic [31:0] n_val;
    logic [7:0]  n_mask;
    if (!rst_n) begin
      m_in_msg   <= 1'b0;
      m_wait_low <= 1'b0;
      m_age      <= 0;
      m_disp     <= ALL_BLANK;
    end else begin
      n_in = m_in_msg; n_wait = m_wait_low; n_age = m_age; n_val = m_val; n_mask = m_mask;
      if (m_in_msg) begin
        n_age = m_age + 1;
        if (n_age == HOLD) begin n_in = 1'b0; n_wait = 1'b1; end
      end else if (m_wait_low) begin
        if (!b_req) n_wait = 1'b0;
      end else if (b_req) begin
        n_in = 1'b1; n_age = 0; n_val = b_val; n_mask = b_mask;
      end
      m_in_msg   <= n_in;
      m_wait_low <= n_wait;
      m_age      <= n_age;
      m_val      <= n_val;
      m_mask     <= n_mask;
      m_disp     <= n_in ? render_b(n_val, n_mask, n_age) : render_a(a_val, a_lzb);
    end
  end

  // Continuous comparison against the model
  always @(negedge ck) begin
    chk("mdl_digits", digits, m_disp);
    chk("mdl_b_ack", 56'(b_ack), 56'(m_wait_low));
    chk("mdl_b_busy", 56'(b_busy), 56'(m_in_msg | m_wait_low));
    chk("mdl_src_b", 56'(src_b), 56'(m_in_msg));
  end

  // Runs one message from the current point; returns the src_b cycle count and
  // the digits seen at message cycles 0 and 8
  task automatic run_msg(input int drop_at, input int reset_at, input int change_at,
                         output int n_src, output logic [55:0] d0, output logic [55:0] d8);
    n_src = 0; d0 = '0; d8 = '0;
    for (int k = 0; k < 4 * HOLD + 20; k++) begin
      @(negedge ck);
      if (src_b) begin
        if (n_src == 0) d0 = digits;
        if (n_src == 8) d8 = digits;
        n_src++;
        #1;
        if (n_src == change_at) begin a_val = 32'h0000BEEF; b_val = 32'h0; b_mask = 8'hFF; end
        if (n_src == drop_at) b_req = 1'b0;
        if (n_src == reset_at) begin #1; rst_n = 1'b0; b_req = 1'b0; return; end
      end else if (n_src > 0) begin
        return;
      end
    end
  endtask

  localparam logic [55:0] MSG_LIT = {7'h7F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00};
  localparam logic [55:0] CAFE_LIT = {7'h31, 7'h08, 7'h38, 7'h30, 7'h01, 7'h4F, 7'h12, 7'h06};

  initial begin
    int n_src;
    logic [55:0] d0, d8;

    // Reset
    repeat (3) @(negedge ck);
    chk("reset_digits", digits, ALL_BLANK);
    chk("reset_flags", 56'({b_ack, b_busy, src_b}), 56'(3'b000));
    #1 rst_n = 1'b1;

    // Decode sweep
    a_lzb = 1'b0; a_val = 32'h89ABCDEF;
    @(negedge ck);
    chk("decode_sweep", digits, {7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38});

    // Leading-zero blanking
    #1 a_lzb = 1'b1; a_val = 32'h00000405;
    @(negedge ck);
    chk("lzb_405", digits, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h4C, 7'h01, 7'h24});
    #1 a_val = 32'h0;
    @(negedge ck);
    chk("lzb_zero", digits, {{7{7'h7F}}, 7'h01});
    #1 a_lzb = 1'b0; a_val = 32'h80000000;
    @(negedge ck);
    chk("lzb_off_msd", digits, {7'h00, {7{7'h01}}});

    // Message with b_req held high; A and B inputs change mid-message
    #1 a_val = 32'hCAFE0123; b_val = 32'h12345678; b_mask = 8'h80; b_req = 1'b1;
    run_msg(-1, -1, 2, n_src, d0, d8);
    chk("msg_src_len", 56'(n_src), 56'(HOLD));
    chk("msg_first", d0, MSG_LIT);
`ifdef SSEG_SCHED_BLINK_EN
    chk("msg_blink8", d8, ALL_BLANK);
`else
    chk("msg_cycle8", d8, MSG_LIT);
`endif
    chk("ack_rise", 56'({b_ack, b_busy, src_b}), 56'(3'b110));
    repeat (5) begin
      @(negedge ck);
      chk("no_retrigger", 56'({b_ack, src_b}), 56'(2'b10));
    end
    chk("ack_shows_a", digits, render_a(32'h0000BEEF, 1'b0));
    #1 b_req = 1'b0;
    @(negedge ck);
    chk("ack_fall", 56'({b_ack, b_busy, src_b}), 56'(3'b000));

    // Early b_req drop still gives a full-length message
    #1 a_val = 32'hCAFE0123; b_val = 32'hFEDCBA98; b_mask = 8'h01; b_req = 1'b1;
    run_msg(3, -1, -1, n_src, d0, d8);
    chk("drop_src_len", 56'(n_src), 56'(HOLD));
    chk("drop_first", d0, {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h7F});
    chk("drop_ack", 56'(b_ack), 56'(1));
    @(negedge ck);
    chk("drop_ack_fall", 56'({b_ack, b_busy}), 56'(2'b00));

    // Reset during message cycle 5 aborts it with no ack
    #1 b_val = 32'h12345678; b_mask = 8'h80; b_req = 1'b1;
    run_msg(-1, 5, -1, n_src, d0, d8);
    #1;
    chk("abort_digits", digits, ALL_BLANK);
    chk("abort_flags", 56'({b_ack, b_busy, src_b}), 56'(3'b000));
    @(negedge ck);
    #1 rst_n = 1'b1;
    @(negedge ck);
    chk("abort_show_a", digits, CAFE_LIT);
    chk("abort_no_ack", 56'({b_ack, b_busy, src_b}), 56'(3'b000));
    repeat (3) @(negedge ck);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
